// File: rtl/higher_memory_arbiter_pkg.sv
// Shared types for the higher-memory arbiter: the memory operation encoding
// used on both the cache side and the backing-memory side, the arbiter FSM
// states, and the round-robin winner rule for two requesters.
package torrence_types;

  localparam int XLEN_DEFAULT = 32;

  // Zero value is MEM_NOP so a reset issue register never looks like a real op.
  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } memory_operation_e;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_RESPOND = 2'd2
  } arb_state_e;

  // Two-way round robin: a lone requester wins outright; under contention
  // the requester that did not win last time goes next.
  function automatic logic rr_winner(input logic [1:0] valid,
                                     input logic       last_grant);
    logic win;
    win = 1'b0;
    case (valid)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_grant;
      default: win = 1'b0;
    endcase
    return win;
  endfunction

endpackage

// File: rtl/higher_memory_arbiter_rr_pick2.sv
// Combinational round-robin pick between two requesters. Produces whether
// anyone is asking and which index wins; no state of its own, the caller
// owns the last-grant register.
module rr_pick2
  import torrence_types::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic       any_o,
  output logic       winner_o
);

  // Winner decode from the pending mask and the previous grant.
  always_comb begin
    any_o    = |valid_i;
    winner_o = rr_winner(valid_i, last_grant_i);
  end

endmodule

// File: rtl/higher_memory_arbiter.sv
// Arbitrates the instruction cache (requester 0) and data cache (requester 1)
// onto a single higher-memory port. One transaction at a time:
//   IDLE    -> pick a winner, latch its request into the issue registers
//   ISSUE   -> present the latched request downstream until memory fulfills
//   RESPOND -> one-cycle fulfilled pulse to the winner, loaded word from the
//              shared response register
// Handshake: a requester holds valid and its fields stable until it sees its
// fulfilled pulse; memory sees mem_req_valid held until it pulses
// mem_req_fulfilled, which is only honoured while in ISSUE. Every output is a
// register or a decode of registered state, so no input reaches an output
// combinationally.
module higher_memory_arbiter
  import torrence_types::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [XLEN-1:0]   r0_req_address,
  input  memory_operation_e r0_req_operation,
  input  logic [XLEN-1:0]   r0_req_store_word,
  input  logic              r0_req_valid,
  output logic [XLEN-1:0]   r0_req_loaded_word,
  output logic              r0_req_fulfilled,

  input  logic [XLEN-1:0]   r1_req_address,
  input  memory_operation_e r1_req_operation,
  input  logic [XLEN-1:0]   r1_req_store_word,
  input  logic              r1_req_valid,
  output logic [XLEN-1:0]   r1_req_loaded_word,
  output logic              r1_req_fulfilled,

  output logic [XLEN-1:0]   mem_req_address,
  output memory_operation_e mem_req_operation,
  output logic [XLEN-1:0]   mem_req_store_word,
  output logic              mem_req_valid,
  input  logic [XLEN-1:0]   mem_req_loaded_word,
  input  logic              mem_req_fulfilled,

  output logic              busy
);

  arb_state_e        state_q;
  logic              last_grant_q;
  logic              grant_id_q;
  logic [XLEN-1:0]   issue_address_q;
  memory_operation_e issue_operation_q;
  logic [XLEN-1:0]   issue_store_word_q;
  logic [XLEN-1:0]   resp_word_q;

  logic              pick_any;
  logic              pick_winner;
  logic [XLEN-1:0]   issue_address_d;
  memory_operation_e issue_operation_d;
  logic [XLEN-1:0]   issue_store_word_d;

  rr_pick2 u_pick (
    .valid_i      ({r1_req_valid, r0_req_valid}),
    .last_grant_i (last_grant_q),
    .any_o        (pick_any),
    .winner_o     (pick_winner)
  );

  // Fields of whichever requester the picker selects; only consumed in IDLE.
  always_comb begin
    issue_address_d    = r0_req_address;
    issue_operation_d  = r0_req_operation;
    issue_store_word_d = r0_req_store_word;
    if (pick_winner) begin
      issue_address_d    = r1_req_address;
      issue_operation_d  = r1_req_operation;
      issue_store_word_d = r1_req_store_word;
    end
  end

  // Arbiter FSM with its issue, grant and response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= ARB_IDLE;
      last_grant_q       <= 1'b1;
      grant_id_q         <= 1'b0;
      issue_address_q    <= '0;
      issue_operation_q  <= MEM_NOP;
      issue_store_word_q <= '0;
      resp_word_q        <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            state_q            <= ARB_ISSUE;
            grant_id_q         <= pick_winner;
            last_grant_q       <= pick_winner;
            issue_address_q    <= issue_address_d;
            issue_operation_q  <= issue_operation_d;
            issue_store_word_q <= issue_store_word_d;
          end
        end
        ARB_ISSUE: begin
          if (mem_req_fulfilled) begin
            resp_word_q <= mem_req_loaded_word;
            state_q     <= ARB_RESPOND;
          end
        end
        ARB_RESPOND: begin
          state_q <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state only.
  always_comb begin
    mem_req_valid      = (state_q == ARB_ISSUE);
    mem_req_address    = issue_address_q;
    mem_req_operation  = issue_operation_q;
    mem_req_store_word = issue_store_word_q;
    r0_req_fulfilled   = (state_q == ARB_RESPOND) && !grant_id_q;
    r1_req_fulfilled   = (state_q == ARB_RESPOND) &&  grant_id_q;
    r0_req_loaded_word = resp_word_q;
    r1_req_loaded_word = resp_word_q;
    busy               = (state_q != ARB_IDLE);
  end

endmodule
